// File: rtl/uart_frame_core.sv
// uart_frame_core: full-duplex UART that packs NUM_WORDS serial frames into each W_OUT stream word
// Ports: clk, rstn (async active-low); rx/tx serial pins (tx idles high);
//   s_valid/s_ready/s_data: TX word stream, lowest frame sent first;
//   m_valid/m_ready/m_data: RX word stream, first frame lands in the lowest bits;
//   frame_err/parity_err/overrun: sticky error flags, cleared by err_clr.
// Optional: define UART_LOOPBACK_EN to add the loopback input (RX fed from TX, tx pin held high).
module uart_frame_core #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int BITS_PER_WORD = 8,
  parameter int W_OUT = 16,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic             tx,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_OUT-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W_OUT-1:0] m_data,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
`ifdef UART_LOOPBACK_EN
  input  logic             loopback,
`endif
  input  logic             err_clr
);
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int PW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_WORD - 1);
  localparam logic [PW-1:0] LAST_WORD = PW'(NUM_WORDS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic ODD = PARITY == 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic lb;
`ifdef UART_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  // ---------------- RX ----------------
  state_t rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0] rx_bit_q, rx_bit_d;
  logic [BITS_PER_WORD-1:0] rx_shift_q, rx_shift_d;
  logic rx_par_bad_q, rx_par_bad_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_in, rx_tick;
  logic [PW-1:0] pack_q, pack_d;
  logic [W_OUT-1:0] buf_q, buf_d, buf_next;
  logic m_valid_q, m_valid_d;
  logic [W_OUT-1:0] m_data_q, m_data_d;
  logic frame_err_q, frame_err_d, parity_err_q, parity_err_d, overrun_q, overrun_d;
  logic new_frame_err, new_par_err, good, word_done, load;
  logic tx_int;

  // Loopback takes the internal tx directly; it is already synchronous to clk.
  assign rx_in = lb ? tx_int : rx_s2_q;
  // START waits half a bit to land mid-bit; every later sample is a full bit apart.
  assign rx_tick = rx_cnt_q == (rx_state_q == START ? HALF : FULL);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    new_frame_err = 1'b0;
    new_par_err = 1'b0;
    good = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_in) rx_state_d = START;
      end
      START: if (rx_tick) begin
        rx_state_d = rx_in ? IDLE : DATA;
        rx_bit_d = '0;
        rx_par_bad_d = 1'b0;
      end
      DATA: if (rx_tick) begin
        rx_shift_d = {rx_in, rx_shift_q[BITS_PER_WORD-1:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == LAST_BIT) rx_state_d = PARITY != 0 ? PAR : STOP;
      end
      PAR: if (rx_tick) begin
        rx_par_bad_d = (^rx_shift_q) ^ rx_in ^ ODD;
        rx_state_d = STOP;
      end
      STOP: if (rx_tick) begin
        rx_state_d = IDLE;
        new_frame_err = !rx_in;
        new_par_err = rx_par_bad_q;
        good = rx_in && !rx_par_bad_q;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_next = buf_q;
    for (int i = 0; i < NUM_WORDS; i++)
      if (pack_q == PW'(i)) buf_next[i*BITS_PER_WORD +: BITS_PER_WORD] = rx_shift_q;
  end

  assign word_done = good && pack_q == LAST_WORD;
  // A completed word loads only if the output slot is empty or being drained this cycle.
  assign load = word_done && (!m_valid_q || m_ready);
  assign buf_d = good ? buf_next : buf_q;
  assign pack_d = good ? (pack_q == LAST_WORD ? '0 : pack_q + 1'b1)
                : (new_frame_err || new_par_err) ? '0 : pack_q;
  assign m_valid_d = load || (m_valid_q && !m_ready);
  assign m_data_d = load ? buf_next : m_data_q;
  // New errors override a simultaneous clear.
  assign frame_err_d = (frame_err_q && !err_clr) || new_frame_err;
  assign parity_err_d = (parity_err_q && !err_clr) || new_par_err;
  assign overrun_d = (overrun_q && !err_clr) || (word_done && m_valid_q && !m_ready);

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_shift_q <= '0;
      rx_par_bad_q <= 1'b0;
      pack_q <= '0;
      buf_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      frame_err_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_in;
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_bad_q <= rx_par_bad_d;
      pack_q <= pack_d;
      buf_q <= buf_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      frame_err_q <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q <= overrun_d;
    end

  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign frame_err = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun = overrun_q;

  // ---------------- TX ----------------
  state_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic tx_stop_q, tx_stop_d;
  logic [PW-1:0] tx_frame_q, tx_frame_d;
  logic [W_OUT-1:0] tx_word_q, tx_word_d;
  logic tx_par_q, tx_par_d, tx_tick;

  assign tx_tick = tx_cnt_q == FULL;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d = (tx_tick || tx_state_q == IDLE) ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_stop_d = tx_stop_q;
    tx_frame_d = tx_frame_q;
    tx_word_d = tx_word_q;
    tx_par_d = tx_par_q;
    case (tx_state_q)
      IDLE: if (s_valid) begin
        tx_word_d = s_data;
        tx_frame_d = '0;
        tx_state_d = START;
      end
      START: if (tx_tick) begin
        tx_state_d = DATA;
        tx_bit_d = '0;
        tx_stop_d = 1'b0;
        tx_par_d = 1'b0;
      end
      // The word shifts right one bit per data bit, so the next frame's bits arrive at the bottom.
      DATA: if (tx_tick) begin
        tx_word_d = tx_word_q >> 1;
        tx_par_d = tx_par_q ^ tx_word_q[0];
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == LAST_BIT) tx_state_d = PARITY != 0 ? PAR : STOP;
      end
      PAR: if (tx_tick) tx_state_d = STOP;
      STOP: if (tx_tick) begin
        tx_stop_d = tx_stop_q + 1'b1;
        if (tx_stop_q == LAST_STOP) begin
          tx_state_d = tx_frame_q == LAST_WORD ? IDLE : START;
          tx_frame_d = tx_frame_q + 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tx_state_q <= IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_stop_q <= 1'b0;
      tx_frame_q <= '0;
      tx_word_q <= '0;
      tx_par_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_stop_q <= tx_stop_d;
      tx_frame_q <= tx_frame_d;
      tx_word_q <= tx_word_d;
      tx_par_q <= tx_par_d;
    end

  // Decoded from registered state only, so reset forces the line high without a clock edge.
  assign tx_int = tx_state_q == START ? 1'b0
                : tx_state_q == DATA ? tx_word_q[0]
                : tx_state_q == PAR ? tx_par_q ^ ODD : 1'b1;
  assign tx = lb | tx_int;
  assign s_ready = tx_state_q == IDLE;
endmodule

// File: tb/tb_uart_frame_core.sv
// tb_uart_frame_core: directed checks of uart_frame_core with no parity (u0) and even parity (u1)
module tb_uart_frame_core;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic tx0, tx1, s_ready0, s_ready1, m_valid0, m_valid1;
  logic s_valid0 = 1'b0, s_valid1 = 1'b0, m_ready0 = 1'b0, m_ready1 = 1'b0;
  logic err_clr0 = 1'b0, err_clr1 = 1'b0;
  logic [15:0] s_data0 = '0, s_data1 = '0, m_data0, m_data1;
  logic fe0, fe1, pe0, pe1, ov0, ov1;
`ifdef UART_LOOPBACK_EN
  logic lb = 1'b0;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_frame_core #(.CLOCKS_PER_PULSE(16), .BITS_PER_WORD(8), .W_OUT(16), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rstn(rstn), .rx(rx0), .tx(tx0), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
`ifdef UART_LOOPBACK_EN
    .loopback(lb),
`endif
    .err_clr(err_clr0));

  uart_frame_core #(.CLOCKS_PER_PULSE(16), .BITS_PER_WORD(8), .W_OUT(16), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rstn(rstn), .rx(rx1), .tx(tx1), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .err_clr(err_clr1));

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx1 = v; else rx0 = v;
    repeat (16) @(negedge clk);
  endtask

  // One serial frame, LSB first; parity bit is even parity of d, inverted when flip=1.
  task automatic send_rx(input bit sel, input logic [7:0] d, input bit pe, input bit flip, input logic st);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (pe) drive_bit(sel, (^d) ^ flip);
    drive_bit(sel, st);
    if (sel) rx1 = 1'b1; else rx0 = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", tx0); end
    total++; if (s_ready0 !== 1'b1) begin bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready0); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (m_valid0 !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid0); end
    total++; if (m_data0 !== 16'h0000) begin bad++; $display("FAIL rst_m_data: got %h want 0000", m_data0); end
    total++; if ({fe0, pe0, ov0, fe1, pe1, ov1} !== 6'b0) begin bad++; $display("FAIL rst_flags: got %b want 000000", {fe0, pe0, ov0, fe1, pe1, ov1}); end
    total++; if (tx0 !== 1'b1 || s_ready0 !== 1'b1) begin bad++; $display("FAIL rst_idle: got tx=%b s_ready=%b want 1 1", tx0, s_ready0); end
  endtask

  task automatic test_tx(input logic [15:0] w);
    int busy;
    bit done;
    int idx;
    logic exp;
    busy = 0;
    done = 0;
    @(negedge clk); s_valid0 = 1'b1; s_data0 = w;
    @(posedge clk); #1; s_valid0 = 1'b0; s_data0 = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (c < 320 && c % 16 == 8) begin
        idx = c / 16;
        exp = idx % 10 == 0 ? 1'b0 : idx % 10 == 9 ? 1'b1 : w[(idx / 10) * 8 + idx % 10 - 1];
        total++; if (tx0 !== exp) begin bad++; $display("FAIL tx_bit%0d word %h: got %b want %b", idx, w, tx0, exp); end
      end
      if (s_ready0 === 1'b1) done = 1; else busy++;
      if (!done) begin @(posedge clk); #1; end
    end
    total++; if (!done || busy != 320) begin bad++; $display("FAIL tx_busy: got %0d cycles (done=%0d) want 320", busy, done); end
  endtask

  task automatic test_rx_hold;
    @(negedge clk);
    send_rx(0, 8'h34, 0, 0, 1'b1);
    send_rx(0, 8'h12, 0, 0, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (m_valid0 !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b want 1", m_valid0); end
    total++; if (m_data0 !== 16'h1234) begin bad++; $display("FAIL hold_data: got %h want 1234", m_data0); end
    repeat (20) @(negedge clk);
    total++; if (m_valid0 !== 1'b1 || m_data0 !== 16'h1234) begin bad++; $display("FAIL hold_still: got %b %h want 1 1234", m_valid0, m_data0); end
    m_ready0 = 1'b1;
    @(negedge clk);
    m_ready0 = 1'b0;
    total++; if (m_valid0 !== 1'b0) begin bad++; $display("FAIL hold_drop: got %b want 0", m_valid0); end
  endtask

  task automatic test_parity;
    @(negedge clk);
    send_rx(1, 8'h99, 1, 0, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (m_valid1 !== 1'b0 || pe1 !== 1'b0) begin bad++; $display("FAIL par_first: got valid=%b pe=%b want 0 0", m_valid1, pe1); end
    send_rx(1, 8'h07, 1, 1, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (pe1 !== 1'b1) begin bad++; $display("FAIL par_err: got %b want 1", pe1); end
    total++; if (m_valid1 !== 1'b0 || fe1 !== 1'b0) begin bad++; $display("FAIL par_noword: got valid=%b fe=%b want 0 0", m_valid1, fe1); end
    send_rx(1, 8'hCD, 1, 0, 1'b1);
    send_rx(1, 8'hAB, 1, 0, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (m_valid1 !== 1'b1 || m_data1 !== 16'hABCD) begin bad++; $display("FAIL par_word: got %b %h want 1 abcd", m_valid1, m_data1); end
    err_clr1 = 1'b1;
    @(negedge clk);
    err_clr1 = 1'b0;
    total++; if (pe1 !== 1'b0) begin bad++; $display("FAIL par_clr: got %b want 0", pe1); end
    m_ready1 = 1'b1;
    @(negedge clk);
    m_ready1 = 1'b0;
  endtask

  task automatic test_overrun;
    @(negedge clk);
    send_rx(0, 8'h11, 0, 0, 1'b1);
    send_rx(0, 8'h11, 0, 0, 1'b1);
    send_rx(0, 8'h22, 0, 0, 1'b1);
    send_rx(0, 8'h22, 0, 0, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (m_valid0 !== 1'b1 || m_data0 !== 16'h1111) begin bad++; $display("FAIL ovr_data: got %b %h want 1 1111", m_valid0, m_data0); end
    total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", ov0); end
    err_clr0 = 1'b1; m_ready0 = 1'b1;
    @(negedge clk);
    err_clr0 = 1'b0; m_ready0 = 1'b0;
    total++; if (ov0 !== 1'b0 || m_valid0 !== 1'b0) begin bad++; $display("FAIL ovr_clr: got ov=%b valid=%b want 0 0", ov0, m_valid0); end
  endtask

  task automatic test_glitch_frame_err;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (m_valid0 !== 1'b0 || {fe0, pe0, ov0} !== 3'b0) begin bad++; $display("FAIL glitch: got valid=%b flags=%b want 0 000", m_valid0, {fe0, pe0, ov0}); end
    send_rx(0, 8'h77, 0, 0, 1'b1);
    send_rx(0, 8'h5A, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (fe0 !== 1'b1) begin bad++; $display("FAIL frame_err: got %b want 1", fe0); end
    total++; if (m_valid0 !== 1'b0) begin bad++; $display("FAIL frame_noword: got %b want 0", m_valid0); end
    send_rx(0, 8'h34, 0, 0, 1'b1);
    send_rx(0, 8'h12, 0, 0, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (m_valid0 !== 1'b1 || m_data0 !== 16'h1234) begin bad++; $display("FAIL frame_repack: got %b %h want 1 1234", m_valid0, m_data0); end
    err_clr0 = 1'b1; m_ready0 = 1'b1;
    @(negedge clk);
    err_clr0 = 1'b0; m_ready0 = 1'b0;
    total++; if (fe0 !== 1'b0) begin bad++; $display("FAIL frame_clr: got %b want 0", fe0); end
  endtask

  task automatic test_reset_mid_tx;
    @(negedge clk); s_valid0 = 1'b1; s_data0 = 16'h0000;
    @(posedge clk); #1; s_valid0 = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    total++; if (tx0 !== 1'b0 || s_ready0 !== 1'b0) begin bad++; $display("FAIL midtx_busy: got tx=%b s_ready=%b want 0 0", tx0, s_ready0); end
    rstn = 1'b0;
    #1;
    total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL midtx_tx: got %b want 1", tx0); end
    total++; if (s_ready0 !== 1'b1) begin bad++; $display("FAIL midtx_s_ready: got %b want 1", s_ready0); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_tx(16'h3C96);
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback;
    bit hi;
    hi = 1;
    lb = 1'b1;
    @(negedge clk); s_valid0 = 1'b1; s_data0 = 16'hBEEF;
    @(negedge clk); s_valid0 = 1'b0;
    for (int c = 0; c < 340; c++) begin
      if (tx0 !== 1'b1) hi = 0;
      @(negedge clk);
    end
    total++; if (!hi) begin bad++; $display("FAIL lb_tx_pin: got low want 1"); end
    total++; if (m_valid0 !== 1'b1 || m_data0 !== 16'hBEEF) begin bad++; $display("FAIL lb_data: got %b %h want 1 beef", m_valid0, m_data0); end
    m_ready0 = 1'b1;
    @(negedge clk);
    m_ready0 = 1'b0;
    lb = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_tx(16'hA55A);
    test_rx_hold;
    test_parity;
    test_overrun;
    test_glitch_frame_err;
    test_reset_mid_tx;
`ifdef UART_LOOPBACK_EN
    test_loopback;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_frame_core.md
Name: uart_frame_core

Overview:
- Parametrised successor to the existing UART top: full-duplex UART with configurable parity, stop-bit count, byte packing and a ready/valid handshake on both streams.
- RX assembles NUM_WORDS serial frames into one W_OUT word, holds it until the consumer accepts it, and reports framing, parity and overrun errors.
- TX serialises one W_OUT word into NUM_WORDS frames.
- Sits between the board pins (rx/tx) and the on-chip stream fabric.

Parameters:
CLOCKS_PER_PULSE, 5208, clk cycles per UART bit (>=4)
BITS_PER_WORD, 8, data bits per serial frame (5..9)
W_OUT, 16, stream word width; must be a multiple of BITS_PER_WORD
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits generated on TX (1 or 2); RX always checks exactly one
NUM_WORDS (localparam), W_OUT/BITS_PER_WORD, frames per stream word

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output, idle high
s_valid  in  1  TX word valid
s_ready  out  1  TX can accept a word
s_data  in  W_OUT  TX word; bits [BITS_PER_WORD-1:0] are sent first
m_valid  out  1  RX word valid
m_ready  in  1  consumer accepts RX word
m_data  out  W_OUT  RX word; the first frame received lands in the lowest bits
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: word completed while m_valid=1 and m_ready=0
err_clr  in  1  clears all sticky flags

Behaviour:
- Reset is asynchronous and active-low. While rstn=0 and after release: tx=1, s_ready=1, m_valid=0, m_data=0, all error flags 0, both FSMs IDLE, pack counters 0.
- Reset asserted mid-frame aborts immediately. tx goes to 1 without waiting for a clock edge.
- RX input: 2-flop synchroniser on rx; all RX logic uses the synchronised signal.
- RX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
- IDLE: a high-to-low transition on synchronised rx starts the bit counter and enters START.
- START: at CLOCKS_PER_PULSE/2, rx is sampled.
  - Sampled high = glitch: return to IDLE, no flags set.
  - Sampled low: proceed; every later sample is taken CLOCKS_PER_PULSE after the previous one (mid-bit).
- DATA: BITS_PER_WORD samples, LSB first.
- PARITY: computed over the data bits; the sampled bit must match the configured mode (even/odd).
- STOP: sample must be 1. RX returns to IDLE right after the stop sample, so it can detect a back-to-back start edge.
- Good frame: stored into byte slot pack_cnt, pack_cnt increments.
- When pack_cnt wraps from NUM_WORDS-1 to 0, the word is complete:
  - m_valid=0, or m_valid&&m_ready in the same cycle: load m_data and set m_valid on the next edge.
  - m_valid=1 && m_ready=0: drop the new word, set overrun; m_data is unchanged.
- Bad frame (parity or stop error): byte discarded, pack_cnt forced to 0, corresponding flag set.
- m_valid clears on m_valid&&m_ready unless a new word loads in the same cycle.
- Sticky flags:
  - err_clr clears all flags on the next edge.
  - A new error in the same cycle as err_clr wins: the flag stays 1.
- TX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> next frame or IDLE.
- Handshake: on s_valid&&s_ready, latch s_data; s_ready=0 and tx=0 (start bit) from the next cycle.
- Frame sequence: each bit lasts exactly CLOCKS_PER_PULSE cycles; frames go out lowest byte first with no gap between frames.
- s_ready returns to 1 in the cycle after the last stop bit of the last frame ends.
- Total busy time per word = NUM_WORDS*(1+BITS_PER_WORD+(PARITY!=0)+STOP_BITS)*CLOCKS_PER_PULSE cycles.
- s_valid with s_ready=0 is ignored. s_data only needs to be stable in the handshake cycle.

Optional Feature:
UART_LOOPBACK_EN
- Defined: adds input port loopback (1 bit).
  - loopback=1: RX FSM takes tx directly, bypassing the synchroniser; the tx pin is held at 1; the rx pin is ignored.
  - loopback=0: normal operation.
- Loopback must only change while both FSMs are IDLE.
- Undefined: no loopback port; behaviour identical to loopback=0.

Test Plan:
- CLOCKS_PER_PULSE=16, PARITY=0, STOP_BITS=1, send s_data=16'hA55A -> tx carries frame 0x5A then 0xA5, each 10 bits x 16 clks (LSB first); s_ready low for exactly 320 cycles.
- Drive frames 0x34 then 0x12 on rx with m_ready=0 -> m_valid=1, m_data=16'h1234; it stays held until m_ready=1, then m_valid drops the next cycle.
- PARITY=1, rx frame 0x07 with parity bit 0 -> parity_err=1, no m_valid; the next two good frames 0xCD, 0xAB give m_data=16'hABCD (pack_cnt was reset); err_clr=1 -> parity_err=0.
- Two complete words 16'h1111, 16'h2222 received with m_ready=0 -> m_data=16'h1111, overrun=1.
- rx low pulse of 4 clks -> no frame, no flags; frame with stop bit 0 -> frame_err=1.
- Assert rstn=0 mid-TX data bit -> tx=1 and s_ready=1 asynchronously; after release, a new word transmits correctly.
- (Only with UART_LOOPBACK_EN defined) loopback=1, send 16'hBEEF -> m_data=16'hBEEF, tx pin stays 1.
